// File: rtl/dmem_bus_demux2.sv
// dmem_bus_demux2: routes data-memory requests from the core's load/store path to
// one of two targets by address decode and returns the selected target's response.
// Only one request is outstanding at a time. The flow is IDLE -> ISSUE -> WAIT -> RESP.
//
// Optional feature macro: DMEM_TIMEOUT_EN. When it is defined, WAIT gives up after
// TIMEOUT_CYCLES cycles and returns resp_err=1. When it is undefined, WAIT holds
// until a response arrives and resp_err is tied to 0.
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   req_*                         core request (valid/ready, we, addr, wdata, wstrb)
//   resp_valid/rdata/err          one-cycle response pulse to the core
//   s0_* / s1_*                   registered request copy to the RAM (s0) and MMIO (s1)
//   sN_ready, sN_resp_*           target handshake and response inputs
module dmem_bus_demux2 #(
   parameter int unsigned          DATA_W         = 32,
   parameter int unsigned          ADDR_W         = 32,
   parameter logic [ADDR_W-1:0]    S1_BASE        = 32'h1000_0000,
   parameter logic [ADDR_W-1:0]    S1_MASK        = 32'hF000_0000,
   parameter int unsigned          TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              s0_valid,
   input  logic              s0_ready,
   output logic              s0_we,
   output logic [ADDR_W-1:0] s0_addr,
   output logic [DATA_W-1:0] s0_wdata,
   output logic [3:0]        s0_wstrb,
   input  logic              s0_resp_valid,
   input  logic [DATA_W-1:0] s0_resp_rdata,
   output logic              s1_valid,
   input  logic              s1_ready,
   output logic              s1_we,
   output logic [ADDR_W-1:0] s1_addr,
   output logic [DATA_W-1:0] s1_wdata,
   output logic [3:0]        s1_wstrb,
   input  logic              s1_resp_valid,
   input  logic [DATA_W-1:0] s1_resp_rdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              s0_valid_q, s0_valid_d;
   logic              s1_valid_q, s1_valid_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              sel_q, sel_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;

`ifdef DMEM_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   logic [CntW-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   // Only the selected target is ever looked at; the other one's handshakes are ignored.
   logic              tgt_ready, tgt_resp_valid;
   logic [DATA_W-1:0] tgt_rdata;
   assign tgt_ready      = sel_q ? s1_ready      : s0_ready;
   assign tgt_resp_valid = sel_q ? s1_resp_valid : s0_resp_valid;
   // Stores always return zero data.
   assign tgt_rdata      = we_q ? '0 : (sel_q ? s1_resp_rdata : s0_resp_rdata);

   always_comb begin
      state_d      = state_q;
      req_ready_d  = 1'b0;
      s0_valid_d   = s0_valid_q;
      s1_valid_d   = s1_valid_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      sel_d        = sel_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            req_ready_d = 1'b1;
            if (req_valid) begin
               we_d        = req_we;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               wstrb_d     = req_wstrb;
               sel_d       = ((req_addr & S1_MASK) == S1_BASE);
               s0_valid_d  = ~sel_d;
               s1_valid_d  = sel_d;
               req_ready_d = 1'b0;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (tgt_ready) begin
               s0_valid_d = 1'b0;
               s1_valid_d = 1'b0;
               if (tgt_resp_valid) begin
                  resp_valid_d = 1'b1;
                  resp_rdata_d = tgt_rdata;
                  state_d      = StResp;
               end else begin
                  state_d = StWait;
`ifdef DMEM_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
         end
         StWait: begin
            if (tgt_resp_valid) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = tgt_rdata;
               state_d      = StResp;
            end
`ifdef DMEM_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               state_d      = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         StResp: begin
            req_ready_d = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         req_ready_q  <= 1'b1;
         s0_valid_q   <= 1'b0;
         s1_valid_q   <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         sel_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         s0_valid_q   <= s0_valid_d;
         s1_valid_q   <= s1_valid_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         sel_q        <= sel_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
`ifdef DMEM_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
`ifdef DMEM_TIMEOUT_EN
   assign resp_err   = resp_err_q;
`else
   assign resp_err   = 1'b0;
`endif

   // Both targets see the same request copy; only valid is per-target.
   assign s0_valid = s0_valid_q;
   assign s1_valid = s1_valid_q;
   assign s0_we    = we_q;
   assign s1_we    = we_q;
   assign s0_addr  = addr_q;
   assign s1_addr  = addr_q;
   assign s0_wdata = wdata_q;
   assign s1_wdata = wdata_q;
   assign s0_wstrb = wstrb_q;
   assign s1_wstrb = wstrb_q;

`ifndef DMEM_TIMEOUT_EN
   logic unused_err;
   assign unused_err = resp_err_q;
`endif

endmodule
